// File: rtl/iir_pkg.sv
// Shared definitions for the time-multiplexed first-order IIR controller:
// float word width, FSM state encoding, shared-unit opcodes and coefficient selects.
package iir_pkg;

    function automatic int flen(input int man, input int exp);
        return man + exp + 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_X = 3'd1,
        ST_MUL_Y = 3'd2,
        ST_ADD   = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    localparam logic FPU_MUL = 1'b0;
    localparam logic FPU_ADD = 1'b1;

    localparam logic CFG_B0  = 1'b0;
    localparam logic CFG_A1N = 1'b1;

endpackage

// File: rtl/iir_chan_bank.sv
// Per-channel register file holding b0, a1_neg and the y[n-1] state.
// One coefficient read port, one state read port, config/state writes and a bulk clear.
module iir_chan_bank
    import iir_pkg::*;
#(
    parameter int MAN  = 23,
    parameter int EXP  = 8,
    parameter int NCH  = 4,
    parameter int CH_W = 2,
    parameter logic [MAN+EXP:0] B0_RST  = 32'hF0E24DD3,
    parameter logic [MAN+EXP:0] A1N_RST = 32'h74FFB7E9,
    localparam int FLEN = flen(MAN, EXP)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH_W-1:0] rd_ch,
    input  logic            rd_sel,
    output logic [FLEN-1:0] rd_coef,
    output logic [FLEN-1:0] rd_ys,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic            cfg_sel,
    input  logic [FLEN-1:0] cfg_data,
    input  logic            ys_we,
    input  logic [CH_W-1:0] ys_ch,
    input  logic [FLEN-1:0] ys_data,
    input  logic            clr
);

    logic [FLEN-1:0] b0_q  [NCH];
    logic [FLEN-1:0] a1n_q [NCH];
    logic [FLEN-1:0] ys_q  [NCH];
    logic [FLEN-1:0] b0_d  [NCH];
    logic [FLEN-1:0] a1n_d [NCH];
    logic [FLEN-1:0] ys_d  [NCH];

    // Reads come straight from the flops, so a same-cycle write is seen next cycle.
    assign rd_coef = (rd_sel == CFG_A1N) ? a1n_q[rd_ch] : b0_q[rd_ch];
    assign rd_ys   = ys_q[rd_ch];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        b0_d  = b0_q;
        a1n_d = a1n_q;
        ys_d  = ys_q;
        if (cfg_we) begin
            if (cfg_sel == CFG_A1N) a1n_d[cfg_ch] = cfg_data;
            else                    b0_d[cfg_ch]  = cfg_data;
        end
        if (ys_we) ys_d[ys_ch] = ys_data;
        if (clr) begin
            for (int i = 0; i < NCH; i++) ys_d[i] = '0;
        end
    end

    // NOTE: this is a small flop array, not a RAM macro, so every entry takes the async reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                b0_q[i]  <= B0_RST;
                a1n_q[i] <= A1N_RST;
                ys_q[i]  <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            b0_q  <= b0_d;
            a1n_q <= a1n_d;
            ys_q  <= ys_d;
        end
    end

endmodule

// File: rtl/iir1_tdm_ctrl.sv
// Schedules NCH first-order float IIR channels onto one shared mul/add unit (MUL_X, MUL_Y, ADD).
// Optional macro IIR_NAN_FLUSH_EN: Inf/NaN results are not fed back and raise sticky flush_flag.
module iir1_tdm_ctrl
    import iir_pkg::*;
#(
    parameter int MAN  = 23,
    parameter int EXP  = 8,
    parameter int NCH  = 4,
    parameter int CH_W = 2,
    parameter logic [MAN+EXP:0] B0_RST  = 32'hF0E24DD3,
    parameter logic [MAN+EXP:0] A1N_RST = 32'h74FFB7E9,
    localparam int FLEN = flen(MAN, EXP)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH_W-1:0] in_ch,
    input  logic [FLEN-1:0] in_x,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic            cfg_sel,
    input  logic [FLEN-1:0] cfg_data,
    input  logic            clr,
    output logic            fpu_op,
    output logic [FLEN-1:0] fpu_a,
    output logic [FLEN-1:0] fpu_b,
    input  logic [FLEN-1:0] fpu_r,
`ifdef IIR_NAN_FLUSH_EN
    output logic            flush_flag,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH_W-1:0] out_ch,
    output logic [FLEN-1:0] out_y
);

    state_e          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [FLEN-1:0] x_q, x_d;
    logic [FLEN-1:0] p0_q, p0_d;
    logic [FLEN-1:0] p1_q, p1_d;
    logic [FLEN-1:0] out_y_q, out_y_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;

    logic            rd_sel;
    logic [FLEN-1:0] rd_coef, rd_ys;
    logic            ys_we;
    logic [FLEN-1:0] ys_data;
    logic            r_special;

    // Exponent field all ones marks Inf or NaN.
    assign r_special = &fpu_r[FLEN-2 -: EXP];

`ifdef IIR_NAN_FLUSH_EN
    logic flush_q, flush_d;
    assign flush_flag = flush_q;
`endif

    iir_chan_bank #(
        .MAN(MAN), .EXP(EXP), .NCH(NCH), .CH_W(CH_W),
        .B0_RST(B0_RST), .A1N_RST(A1N_RST)
    ) u_bank (
        .clk(clk), .rst(rst),
        .rd_ch(ch_q), .rd_sel(rd_sel), .rd_coef(rd_coef), .rd_ys(rd_ys),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .ys_we(ys_we), .ys_ch(ch_q), .ys_data(ys_data),
        .clr(clr)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign out_ch    = out_ch_q;
    assign out_y     = out_y_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        x_d      = x_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        out_y_d  = out_y_q;
        out_ch_d = out_ch_q;
        fpu_op   = FPU_MUL;
        fpu_a    = '0;
        fpu_b    = '0;
        rd_sel   = CFG_B0;
        ys_we    = 1'b0;
        ys_data  = fpu_r;
`ifdef IIR_NAN_FLUSH_EN
        flush_d  = flush_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ch_d    = in_ch;
                    x_d     = in_x;
                    state_d = ST_MUL_X;
                end
            end
            ST_MUL_X: begin
                fpu_a   = rd_coef;
                fpu_b   = x_q;
                p0_d    = fpu_r;
                state_d = ST_MUL_Y;
            end
            ST_MUL_Y: begin
                rd_sel  = CFG_A1N;
                fpu_a   = rd_coef;
                fpu_b   = rd_ys;
                p1_d    = fpu_r;
                state_d = ST_ADD;
            end
            ST_ADD: begin
                fpu_op   = FPU_ADD;
                fpu_a    = p0_q;
                fpu_b    = p1_q;
                out_y_d  = fpu_r;
                out_ch_d = ch_q;
                ys_we    = 1'b1;
`ifdef IIR_NAN_FLUSH_EN
                if (r_special) begin
                    ys_data = '0;
                    flush_d = 1'b1;
                end
`endif
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef IIR_NAN_FLUSH_EN
        if (clr) flush_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            x_q      <= '0;
            p0_q     <= '0;
            p1_q     <= '0;
            out_y_q  <= '0;
            out_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            x_q      <= x_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            out_y_q  <= out_y_d;
            out_ch_q <= out_ch_d;
        end
    end

`ifdef IIR_NAN_FLUSH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) flush_q <= 1'b0;
        else     flush_q <= flush_d;
    end
`else
    logic unused_special;
    assign unused_special = r_special;
`endif

endmodule

// File: tb/tb_iir1_tdm_ctrl.sv
// Scoreboard bench for iir1_tdm_ctrl with an ideal float mul/add model of the shared unit.
module tb_iir1_tdm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  in_ch;
    logic [31:0] in_x;
    logic        cfg_we, cfg_sel, clr;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_data;
    logic        fpu_op;
    logic [31:0] fpu_a, fpu_b, fpu_r;
    logic        out_valid, out_ready;
    logic [1:0]  out_ch;
    logic [31:0] out_y;
`ifdef IIR_NAN_FLUSH_EN
    logic        flush_flag;
`endif

    iir1_tdm_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_x(in_x),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .clr(clr),
        .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_r(fpu_r),
`ifdef IIR_NAN_FLUSH_EN
        .flush_flag(flush_flag),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_y(out_y)
    );

    always #5 clk = ~clk;

    // Single <-> double conversion for normals, zero and Inf (enough for these vectors).
    function automatic real s2r(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:23] == 8'h00)      e = 11'h000;
        else if (s[30:23] == 8'hFF) e = 11'h7FF;
        else                        e = {3'b000, s[30:23]} + 11'd896;
        return $bitstoreal({s[31], e, s[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [7:0]  es;
        d = $realtobits(r);
        if (d[62:52] == 11'h000)      es = 8'h00;
        else if (d[62:52] == 11'h7FF) es = 8'hFF;
        else                          es = 8'(d[62:52] - 11'd896);
        return {d[63], es, d[51:29]};
    endfunction

    always_comb begin
        fpu_r = fpu_op ? r2s(s2r(fpu_a) + s2r(fpu_b)) : r2s(s2r(fpu_a) * s2r(fpu_b));
    end

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] y;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: latency on out_valid rise, pop/compare on each output handshake.
    always @(negedge clk) begin
        ov_prev <= rst ? 1'b0 : out_valid;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got ch=%0d y=%h, expected none", out_ch, out_y);
            end else begin
                if (!ov_prev) check("latency", 32'(cyc - exp_q[0].acc), 32'd3);
                if (out_ready) begin
                    check("out_ch", {30'd0, out_ch}, {30'd0, exp_q[0].ch});
                    check("out_y", out_y, exp_q[0].y);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cfg(input logic [1:0] ch, input logic sel, input logic [31:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [1:0] ch, input logic [31:0] x, input bit push,
                        input logic [31:0] ey);
        bit ok;
        @(negedge clk);
        in_ch = ch; in_x = x; in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 100 cycles");
        end
        if (push) exp_q.push_back('{ch, ey, cyc + 1});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_x = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;
        clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_y", out_y, 32'd0);
        check("rst_out_ch", {30'd0, out_ch}, 32'd0);
        check("rst_fpu_a", fpu_a, 32'd0);
        check("rst_fpu_b", fpu_b, 32'd0);
        rst = 1'b0;

        cfg(2'd0, 1'b0, 32'h3F800000);
        cfg(2'd0, 1'b1, 32'h3F000000);
        cfg(2'd1, 1'b0, 32'h3F800000);
        cfg(2'd1, 1'b1, 32'h00000000);
        cfg(2'd2, 1'b0, 32'h3F800000);
        cfg(2'd2, 1'b1, 32'h3F800000);

        // Impulse response on ch0, then ch1 isolation.
        send(2'd0, 32'h3F800000, 1'b1, 32'h3F800000);
        send(2'd0, 32'h00000000, 1'b1, 32'h3F000000);
        send(2'd0, 32'h00000000, 1'b1, 32'h3E800000);
        send(2'd1, 32'h40000000, 1'b1, 32'h40000000);
        send(2'd0, 32'h00000000, 1'b1, 32'h3E000000);
        drain();

        // Backpressure: output held for 3 cycles.
        out_ready = 1'b0;
        send(2'd0, 32'h00000000, 1'b1, 32'h3D800000);
        for (int n = 0; n < 20; n++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_y", out_y, 32'h3D800000);
            check("bp_out_ch", {30'd0, out_ch}, 32'd0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        drain();

        // Clear coinciding with ADD: out_y keeps the sum, ys is zeroed.
        send(2'd0, 32'h3F800000, 1'b1, 32'h3F840000);
        @(posedge clk);
        @(posedge clk);
        #1 clr = 1'b1;
        check("add_fpu_op", {31'd0, fpu_op}, 32'd1);
        @(posedge clk);
        #1 clr = 1'b0;
        drain();
        send(2'd0, 32'h3F800000, 1'b1, 32'h3F800000);
        drain();

`ifdef IIR_NAN_FLUSH_EN
        send(2'd2, 32'h7F800000, 1'b1, 32'h7F800000);
        drain();
        check("flush_flag_set", {31'd0, flush_flag}, 32'd1);
        send(2'd2, 32'h00000000, 1'b1, 32'h00000000);
        drain();
        check("flush_flag_sticky", {31'd0, flush_flag}, 32'd1);
`endif

        // Reset during MUL_Y drops the sample and restores defaults.
        send(2'd0, 32'h3F800000, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("muly_fpu_a", fpu_a, 32'h3F000000);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_fpu_a", fpu_a, 32'd0);
        check("midrst_out_y", out_y, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
`ifdef IIR_NAN_FLUSH_EN
        check("rst_flush_flag", {31'd0, flush_flag}, 32'd0);
`endif
        send(2'd0, 32'h3F800000, 1'b1, 32'hF0E24DD3);
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/iir1_tdm_ctrl.md
Name: iir1_tdm_ctrl

Overview:
Time-division scheduler that runs NCH independent first-order float IIR channels (y = b0·x + a1_neg·y[n-1]) on one shared float multiply/add unit.
- Holds per-channel coefficients and state.
- Sequences the unit over three operation cycles per sample.
- Uses valid/ready handshakes on the input and output streams.
- Sits between the int-to-float front end and downstream float consumers.

Parameters:
MAN, 23, mantissa width; float word width FLEN = MAN+EXP+1
EXP, 8, exponent width
NCH, 4, number of channels (power of two, ≥2)
CH_W, 2, channel index width = log2(NCH)
B0_RST, 32'hF0E24DD3, reset value of every channel's b0
A1N_RST, 32'h74FFB7E9, reset value of every channel's a1_neg

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  controller can accept a sample
in_ch  in  CH_W  channel of the input sample
in_x  in  FLEN  float input sample
cfg_we  in  1  coefficient write strobe
cfg_ch  in  CH_W  coefficient channel
cfg_sel  in  1  0 = b0, 1 = a1_neg
cfg_data  in  FLEN  coefficient value
clr  in  1  synchronous clear of all y state
fpu_op  out  1  0 = multiply, 1 = add
fpu_a  out  FLEN  shared unit operand A
fpu_b  out  FLEN  shared unit operand B
fpu_r  in  FLEN  shared unit result (combinational, same cycle)
out_valid  out  1  output valid
out_ready  in  1  downstream accepts output
out_ch  out  CH_W  channel of the output
out_y  out  FLEN  filtered output

Behaviour:
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch in_ch/in_x, go to MUL_X.
  - MUL_X: fpu_op=0, fpu_a=b0[ch], fpu_b=x; p0<=fpu_r. Go to MUL_Y.
  - MUL_Y: fpu_op=0, fpu_a=a1n[ch], fpu_b=ys[ch]; p1<=fpu_r. Go to ADD.
  - ADD: fpu_op=1, fpu_a=p0, fpu_b=p1; out_y<=fpu_r; ys[ch]<=fpu_r. Go to OUT.
  - OUT: out_valid=1 with out_ch/out_y stable. Hold until out_ready; on the handshake edge go to IDLE.
- in_ready=0 in every state except IDLE.
- In IDLE and OUT: fpu_op=0, fpu_a=0, fpu_b=0.
- Latency and throughput: sample accepted at edge E0, out_valid high after E3. Minimum 5 cycles per sample.
- Config writes:
  - Applied at the clock edge in any state.
  - A read in the same cycle as a write to that register returns the old value.
- clr:
  - Zeroes all ys at the edge.
  - If clr coincides with the ADD write-back, clear wins for ys; out_y still captures fpu_r.
- Reset (asynchronous, any time, including mid-sample):
  - state=IDLE, out_valid=0, out_y=0, out_ch=0, p0=p1=0.
  - All ys=0, all b0=B0_RST, all a1n=A1N_RST.
  - The in-flight sample is dropped.
- Channel wrap: none; in_ch is taken modulo NCH by width.
- The controller does no arithmetic itself; all float math is done by the shared unit.

Optional Feature:
- Macro IIR_NAN_FLUSH_EN.
- Defined: in ADD, if the fpu_r exponent field is all ones (Inf/NaN):
  - ys[ch] is written with 0 instead of fpu_r.
  - out_y is still fpu_r.
  - A sticky output flush_flag (1 bit, cleared by rst or clr) is set.
- Undefined: fpu_r is always written to ys, and the flush_flag port is absent.

Decomposition:
- Package iir_pkg holds:
  - the FLEN localparam function
  - the FSM state enum (IDLE, MUL_X, MUL_Y, ADD, OUT)
  - FPU_MUL=0 and FPU_ADD=1 encodings
  - CFG_B0=0 and CFG_A1N=1 encodings
- One sub-module, iir_chan_bank: the per-channel b0/a1n/ys register file.
  - Async reset.
  - Two combinational read ports.
  - Config write port, state write port, clear.

Test Plan:
- The bench models the shared unit as an ideal float mul/add.
- Impulse: cfg ch0 b0=3F800000, a1n=3F000000; x=3F800000, then 00000000, then 00000000 → out_y=3F800000, 3F000000, 3E800000; out_valid high exactly 3 edges after each accept.
- Channel isolation: after the impulse, send ch1 x=40000000 (ch1 b0=3F800000, a1n=0) → out_ch=1, out_y=40000000; next ch0 x=0 → out_y=3E000000.
- Backpressure: hold out_ready=0 for 3 cycles in OUT → out_valid, out_y, out_ch held stable, in_ready=0; after out_ready=1, in_ready=1 on the next cycle.
- Reset mid-sample: assert rst during MUL_Y → out_valid=0 immediately. After release, ch0 with x=3F800000 gives out_y = B0_RST·1.0 with ys = 0.
- Clear collision: clr asserted in the ADD cycle → out_y = the computed value; the next sample on the same channel sees ys=0.
- IIR_NAN_FLUSH_EN: a1n=3F800000, x=7F800000 → out_y=7F800000 and flush_flag=1; next x=0 → out_y=00000000.
